rf_param: RTL and testbench
===========================

RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register and data port in bits.
REQ-002 Parameter ADDR_W, default 4, pointer width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  reset is synchronous and active-high.
REQ-007 we  input  1  write enable for port W.
REQ-008 ptr_w  input  ADDR_W  write address; also the store_in read address.
REQ-009 ptr_a  input  ADDR_W  read port A address.
REQ-010 ptr_b  input  ADDR_W  read port B address.
REQ-011 di  input  WIDTH  write data.
REQ-012 ovf_we  input  1  load enable for the overflow flag register.
REQ-013 ovf_in  input  1  overflow value from the ALU.
REQ-014 do_a  output  WIDTH  read data A.
REQ-015 do_b  output  WIDTH  read data B.
REQ-016 store_in  output  WIDTH  contents of register ptr_w (store-data path).
REQ-017 ovf_out  output  1  current overflow flag.
REQ-018 ready  output  1  high when the clear sequence is done and writes are accepted.

Function
REQ-019 The block SHALL have a two-state FSM: CLEAR and RUN.
REQ-020 In CLEAR, a clear counter clr_idx (ADDR_W bits) SHALL write zero to register clr_idx each cycle and increment by 1.
REQ-021 CLEAR SHALL transition to RUN on the cycle clr_idx == DEPTH-1 is written; clear takes exactly DEPTH cycles.
REQ-022 RUN SHALL be held until reset; no other transition exists.
REQ-023 ready SHALL be 1 only in RUN (registered state, not combinational on counter).
REQ-024 In CLEAR, we SHALL be ignored and do_a, do_b, store_in SHALL read 0.
REQ-025 In RUN, when we=1, register ptr_w SHALL load di at the rising edge; no write-through to state occurs without we.
REQ-026 With ZERO_REG=1, writes to address 0 SHALL be discarded and any read of address 0 SHALL return 0.
REQ-027 Reads are combinational: do_a = reg[ptr_a], do_b = reg[ptr_b], store_in = reg[ptr_w], zero latency.
REQ-028 With BYPASS=1 in RUN, if we=1 and ptr_a==ptr_w (and not the zero register), do_a SHALL equal di in the same cycle; same rule for do_b; store_in is never bypassed.
REQ-029 With BYPASS=0, reads SHALL return the pre-write value during the write cycle and the new value from the next cycle.
REQ-030 ptr_a == ptr_b SHALL return identical data on both ports.
REQ-031 ovf_out SHALL load ovf_in on any cycle with ovf_we=1 in RUN and hold otherwise; ovf_we and we are independent and may coincide.
REQ-032 Pointers wrap naturally over DEPTH; no out-of-range address exists.

Reset
REQ-033 reset=1 at a clock edge SHALL set state to CLEAR, clr_idx to 0, ovf_out to 0, ready to 0.
REQ-034 reset asserted mid-CLEAR SHALL restart clearing from address 0.
REQ-035 reset asserted in RUN SHALL discard any concurrent write and restart the full DEPTH-cycle clear.
REQ-036 Register contents SHALL be 0 for all addresses once ready rises after any reset.

Verification
REQ-037 Reset 1 cycle, release -> ready=0 for exactly 16 cycles (DEPTH=16), then 1; reads of all 16 addresses return 0x00.
REQ-038 In RUN, we=1 ptr_w=3 di=0xA5, ptr_a=3 same cycle -> do_a=0xA5 (BYPASS=1); next cycle we=0 -> do_a=0xA5, store_in=0xA5 with ptr_w=3.
REQ-039 Write ptr_w=0 di=0xFF -> do_a with ptr_a=0 returns 0x00 that cycle and after (ZERO_REG=1).
REQ-040 ovf_we=1 ovf_in=1 with we=1 ptr_w=5 di=0x12 -> next cycle ovf_out=1 and reg5=0x12; ovf_we=0 ovf_in=0 -> ovf_out stays 1.
REQ-041 Write reg7=0x3C, then reset at clear cycle 5, release -> ready rises 16 cycles after release, reg7 reads 0x00.
REQ-042 BYPASS=0 instance: we=1 ptr_w=2 di=0x55 with ptr_b=2 -> do_b=old value 0x00 that cycle, 0x55 next cycle.

Source files
------------

// File: rtl/rf_param.sv
// Parameterised multi-port register file with a power-on clear sequence,
// optional hardwired zero register, optional write-to-read bypass and an overflow flag.
module rf_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] ptr_w,
  input  logic [ADDR_W-1:0] ptr_a,
  input  logic [ADDR_W-1:0] ptr_b,
  input  logic [WIDTH-1:0]  di,
  input  logic              ovf_we,
  input  logic              ovf_in,
  output logic [WIDTH-1:0]  do_a,
  output logic [WIDTH-1:0]  do_b,
  output logic [WIDTH-1:0]  store_in,
  output logic              ovf_out,
  output logic              ready,
  output logic              fsm_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic run;
  logic zero_a, zero_b, zero_w;
  logic byp_a, byp_b;

  // Control FSM. ready is its own flop, raised on the last clear write so it
  // lines up exactly with the CLEAR->RUN transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ovf_out <= 1'b0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (ovf_we) ovf_out <= ovf_in;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage array: cleared one entry per cycle in CLEAR, written by port W in RUN.
  // A reset edge suppresses any concurrent write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (we && !(ZERO_REG && (ptr_w == '0))) begin
        mem[ptr_w] <= di;
      end
    end
  end

  assign run       = (state == RUN);
  assign fsm_state = (state == RUN);

  assign zero_a = ZERO_REG && (ptr_a == '0);
  assign zero_b = ZERO_REG && (ptr_b == '0);
  assign zero_w = ZERO_REG && (ptr_w == '0);

  // Zero-register check takes precedence, so register 0 is never bypassed.
  assign byp_a = BYPASS && we && (ptr_a == ptr_w);
  assign byp_b = BYPASS && we && (ptr_b == ptr_w);

  assign do_a     = (!run || zero_a) ? '0 : (byp_a ? di : mem[ptr_a]);
  assign do_b     = (!run || zero_b) ? '0 : (byp_b ? di : mem[ptr_b]);
  assign store_in = (!run || zero_w) ? '0 : mem[ptr_w];

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: a default instance plus a BYPASS=0 instance
// sharing the same stimulus.
module tb_rf_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [3:0] ptr_w, ptr_a, ptr_b;
  logic [7:0] di;
  logic       ovf_we, ovf_in;

  logic [7:0] do_a, do_b, store_in;
  logic       ovf_out, ready, fsm_state;
  logic [7:0] do_a_nb, do_b_nb, store_in_nb;
  logic       ovf_out_nb, ready_nb, fsm_state_nb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_param dut (
    .clk(clk), .reset(reset), .we(we), .ptr_w(ptr_w), .ptr_a(ptr_a), .ptr_b(ptr_b),
    .di(di), .ovf_we(ovf_we), .ovf_in(ovf_in), .do_a(do_a), .do_b(do_b),
    .store_in(store_in), .ovf_out(ovf_out), .ready(ready), .fsm_state(fsm_state)
  );

  rf_param #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .ptr_w(ptr_w), .ptr_a(ptr_a), .ptr_b(ptr_b),
    .di(di), .ovf_we(ovf_we), .ovf_in(ovf_in), .do_a(do_a_nb), .do_b(do_b_nb),
    .store_in(store_in_nb), .ovf_out(ovf_out_nb), .ready(ready_nb), .fsm_state(fsm_state_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After a single reset edge, ready must stay low for the first 15 edges
  // after release and be high on the 16th; reads stay zero throughout.
  task automatic check_clear(input string tag);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk({tag, "_ready"}, {31'b0, ready}, {31'b0, (i == 16)});
      if (i < 16) begin
        chk({tag, "_do_a_clr"}, {24'b0, do_a}, 32'h0);
        chk({tag, "_store_clr"}, {24'b0, store_in}, 32'h0);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we = 1'b0; ptr_w = '0; ptr_a = '0; ptr_b = '0;
    di = '0; ovf_we = 1'b0; ovf_in = 1'b0;
    tick();
    reset = 1'b0;
    // Reset state
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_ovf", {31'b0, ovf_out}, 32'h0);
    chk("rst_state", {31'b0, fsm_state}, 32'h0);
    // Writes during clear must be ignored, and nothing bypassed
    we = 1'b1; ptr_w = 4'd4; ptr_a = 4'd4; di = 8'h77;
    ovf_we = 1'b1; ovf_in = 1'b1;
    #1;
    chk("clr_bypass_a", {24'b0, do_a}, 32'h0);
    check_clear("clr1");
    we = 1'b0; ovf_we = 1'b0; ovf_in = 1'b0;
    #1;
    chk("run_state", {31'b0, fsm_state}, 32'h1);
    chk("run_ovf_ignored_clr", {31'b0, ovf_out}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      ptr_a = 4'(k); ptr_b = 4'(15 - k); ptr_w = 4'(k);
      #1;
      chk("clr_all_a", {24'b0, do_a}, 32'h0);
      chk("clr_all_b", {24'b0, do_b}, 32'h0);
      chk("clr_all_st", {24'b0, store_in}, 32'h0);
    end

    // Bypass write to reg 3
    we = 1'b1; ptr_w = 4'd3; di = 8'hA5; ptr_a = 4'd3; ptr_b = 4'd1;
    #1;
    chk("byp_a", {24'b0, do_a}, 32'hA5);
    chk("byp_store_not_bypassed", {24'b0, store_in}, 32'h0);
    chk("nb_a_old", {24'b0, do_a_nb}, 32'h0);
    chk("byp_b_other", {24'b0, do_b}, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("wr3_a", {24'b0, do_a}, 32'hA5);
    chk("wr3_store", {24'b0, store_in}, 32'hA5);
    chk("nb_wr3_a", {24'b0, do_a_nb}, 32'hA5);

    // Zero register
    we = 1'b1; ptr_w = 4'd0; di = 8'hFF; ptr_a = 4'd0;
    #1;
    chk("zero_a_wcycle", {24'b0, do_a}, 32'h0);
    tick();
    we = 1'b0;
    #1;
    chk("zero_a_after", {24'b0, do_a}, 32'h0);
    chk("zero_store", {24'b0, store_in}, 32'h0);

    // Overflow flag with concurrent write
    ovf_we = 1'b1; ovf_in = 1'b1; we = 1'b1; ptr_w = 4'd5; di = 8'h12;
    tick();
    ovf_we = 1'b0; ovf_in = 1'b0; we = 1'b0; ptr_a = 4'd5; ptr_b = 4'd5;
    #1;
    chk("ovf_set", {31'b0, ovf_out}, 32'h1);
    chk("reg5_a", {24'b0, do_a}, 32'h12);
    chk("same_ptr_b", {24'b0, do_b}, 32'h12);
    tick();
    chk("ovf_hold", {31'b0, ovf_out}, 32'h1);
    // Write without we must not change state
    di = 8'hEE;
    tick();
    chk("no_we_reg5", {24'b0, do_a}, 32'h12);

    // Pointer at top of range and wrap neighbour
    we = 1'b1; ptr_w = 4'd15; di = 8'hC3;
    tick();
    we = 1'b0; ptr_a = 4'd15; ptr_b = 4'd14;
    #1;
    chk("reg15_a", {24'b0, do_a}, 32'hC3);
    chk("reg14_b", {24'b0, do_b}, 32'h0);

    // BYPASS=0 instance on port B
    we = 1'b1; ptr_w = 4'd2; di = 8'h55; ptr_b = 4'd2;
    #1;
    chk("nb_b_old", {24'b0, do_b_nb}, 32'h0);
    chk("byp_b_new", {24'b0, do_b}, 32'h55);
    tick();
    we = 1'b0;
    #1;
    chk("nb_b_new", {24'b0, do_b_nb}, 32'h55);

    // Reset in RUN discards a concurrent write; reset mid-clear restarts
    we = 1'b1; ptr_w = 4'd7; di = 8'h3C;
    tick();
    we = 1'b0; ptr_a = 4'd7;
    #1;
    chk("reg7_a", {24'b0, do_a}, 32'h3C);
    reset = 1'b1; we = 1'b1; ptr_w = 4'd9; di = 8'h99;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    chk("rst2_ready", {31'b0, ready}, 32'h0);
    chk("rst2_ovf", {31'b0, ovf_out}, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_clr_ready", {31'b0, ready}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_clear("clr2");
    ptr_a = 4'd7; ptr_b = 4'd9; ptr_w = 4'd3;
    #1;
    chk("reg7_cleared", {24'b0, do_a}, 32'h0);
    chk("reg9_discarded", {24'b0, do_b}, 32'h0);
    chk("reg3_cleared", {24'b0, store_in}, 32'h0);
    chk("ovf_after_rst", {31'b0, ovf_out}, 32'h0);

    // Overflow can be cleared again
    ovf_we = 1'b1; ovf_in = 1'b1;
    tick();
    ovf_in = 1'b0;
    tick();
    ovf_we = 1'b0;
    #1;
    chk("ovf_clear", {31'b0, ovf_out}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
